// File: rtl/bit_flip_pkg.sv
// ---------------------------------------------------------------------------
// bit_flip_pkg
//
// Purpose:
//   Shared definitions for the FFT writeback address path. This package holds
//   the one common bit-reverse function, so every block that needs the
//   bit-reversed ordering uses the same definition of it.
//
// Contents:
//   DEFAULT_WORD_SIZE - default data word width used by bit_flip and its lanes
//   DEFAULT_ADDR_SIZE - default address width used by bit_flip and its lanes
//   MAX_ADDR_SIZE     - widest address the reverse function supports
//   wide_addr_t       - address container wide enough for any supported width
//   bit_reverse()     - reverses the low 'width' bits of an address
// ---------------------------------------------------------------------------
package bit_flip_pkg;

  localparam int DEFAULT_WORD_SIZE = 74;
  localparam int DEFAULT_ADDR_SIZE = 5;
  localparam int MAX_ADDR_SIZE     = 32;

  typedef logic [MAX_ADDR_SIZE-1:0] wide_addr_t;

  // The address sits right-justified in a MAX_ADDR_SIZE container with zeros
  // above it. Mirroring the whole container moves the address bits to the top
  // in reversed order, and shifting back down by the unused headroom leaves
  // result bit k equal to input bit width-1-k. A width of 1 is the identity.
  function automatic wide_addr_t bit_reverse(input wide_addr_t addr,
                                             input int         width);
    wide_addr_t mirrored;
    mirrored = {<<{addr}};
    return mirrored >> (MAX_ADDR_SIZE - width);
  endfunction

endpackage

// File: rtl/bit_flip_if.sv
// ---------------------------------------------------------------------------
// bit_flip_if
//
// Purpose:
//   Bundles the two-lane address/data pipe that passes through bit_flip.
//   There is no handshake: a new pair is presented on every clock.
//
// Parameters:
//   WORD_SIZE - data word width in bits
//   ADDR_SIZE - address width in bits
//
// Signals:
//   i_pipeaddr_A / i_pipeaddr_B - source addresses for lanes A and B
//   i_pipedata_A / i_pipedata_B - data words for lanes A and B
//   o_pipeaddr_A / o_pipeaddr_B - registered, bit-reversed addresses
//   o_pipedata_A / o_pipedata_B - registered data words
//
// Modports:
//   master - the upstream stage: drives the i_* side, observes the o_* side
//   slave  - bit_flip itself: consumes the i_* side, drives the o_* side
// ---------------------------------------------------------------------------
interface bit_flip_if
  import bit_flip_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
  parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE
) ();

  logic [ADDR_SIZE-1:0] i_pipeaddr_A;
  logic [ADDR_SIZE-1:0] i_pipeaddr_B;
  logic [WORD_SIZE-1:0] i_pipedata_A;
  logic [WORD_SIZE-1:0] i_pipedata_B;

  logic [ADDR_SIZE-1:0] o_pipeaddr_A;
  logic [ADDR_SIZE-1:0] o_pipeaddr_B;
  logic [WORD_SIZE-1:0] o_pipedata_A;
  logic [WORD_SIZE-1:0] o_pipedata_B;

  modport master (
    output i_pipeaddr_A,
    output i_pipeaddr_B,
    output i_pipedata_A,
    output i_pipedata_B,
    input  o_pipeaddr_A,
    input  o_pipeaddr_B,
    input  o_pipedata_A,
    input  o_pipedata_B
  );

  modport slave (
    input  i_pipeaddr_A,
    input  i_pipeaddr_B,
    input  i_pipedata_A,
    input  i_pipedata_B,
    output o_pipeaddr_A,
    output o_pipeaddr_B,
    output o_pipedata_A,
    output o_pipedata_B
  );

endinterface

// File: rtl/bit_flip_lane.sv
// ---------------------------------------------------------------------------
// bit_flip_lane
//
// Purpose:
//   One lane of the bit_flip stage: a single address register that captures
//   the bit-reversed source address and a single data register that captures
//   the data word unchanged. Both registers load on every rising edge, so the
//   address and its data leave the lane together one cycle after entering.
//
// Parameters:
//   WORD_SIZE - data word width in bits (>= 1)
//   ADDR_SIZE - address width in bits (1 .. MAX_ADDR_SIZE)
//
// Ports:
//   i_CLK    - clock, rising edge
//   i_RST    - asynchronous, active-high reset; clears both registers
//   src_addr - incoming address
//   src_data - incoming data word
//   dst_addr - registered bit-reversed address
//   dst_data - registered data word
// ---------------------------------------------------------------------------
module bit_flip_lane
  import bit_flip_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
  parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE
) (
  input  logic                 i_CLK,
  input  logic                 i_RST,
  input  logic [ADDR_SIZE-1:0] src_addr,
  input  logic [WORD_SIZE-1:0] src_data,
  output logic [ADDR_SIZE-1:0] dst_addr,
  output logic [WORD_SIZE-1:0] dst_data
);

  // Address and data share one register stage so the pair stays aligned.
  // Reset is asynchronous so the outputs drop to zero the moment i_RST rises
  // and whatever pair was about to be captured is simply discarded. The
  // address is widened into the package container, reversed there, and cut
  // back to ADDR_SIZE bits; no offset is added here, that is the caller's job.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      dst_addr <= '0;
      dst_data <= '0;
    end else begin
      dst_addr <= ADDR_SIZE'(bit_reverse(wide_addr_t'(src_addr), ADDR_SIZE));
      dst_data <= src_data;
    end
  end

endmodule

// File: rtl/bit_flip.sv
// ---------------------------------------------------------------------------
// bit_flip
//
// Purpose:
//   Bit-reversal stage of the FFT writeback pipeline. Two independent lanes
//   (A and B) each take an address/data pair every clock and present, one
//   cycle later, the bit-reversed address with its data word unchanged. There
//   is no enable, stall or handshake, and no path from any input to any
//   output that does not pass through a flop.
//
// Parameters:
//   WORD_SIZE - data word width in bits (default 74, minimum 1)
//   ADDR_SIZE - address width in bits to be reversed (default 5, minimum 1)
//
// Ports:
//   i_CLK - clock, all state updates on the rising edge
//   i_RST - asynchronous, active-high reset; forces all outputs to zero
//   pipe  - bit_flip_if slave modport carrying both lanes:
//             i_pipeaddr_A/B, i_pipedata_A/B in,
//             o_pipeaddr_A/B, o_pipedata_A/B out
// ---------------------------------------------------------------------------
module bit_flip
  import bit_flip_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
  parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE
) (
  input  logic       i_CLK,
  input  logic       i_RST,
  bit_flip_if.slave  pipe
);

  // Lane A. The lanes share nothing but clock and reset, so equal or swapped
  // addresses on A and B need no arbitration.
  bit_flip_lane #(
    .WORD_SIZE (WORD_SIZE),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_lane_a (
    .i_CLK    (i_CLK),
    .i_RST    (i_RST),
    .src_addr (pipe.i_pipeaddr_A),
    .src_data (pipe.i_pipedata_A),
    .dst_addr (pipe.o_pipeaddr_A),
    .dst_data (pipe.o_pipedata_A)
  );

  // Lane B, identical to lane A.
  bit_flip_lane #(
    .WORD_SIZE (WORD_SIZE),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_lane_b (
    .i_CLK    (i_CLK),
    .i_RST    (i_RST),
    .src_addr (pipe.i_pipeaddr_B),
    .src_data (pipe.i_pipedata_B),
    .dst_addr (pipe.o_pipeaddr_B),
    .dst_data (pipe.o_pipedata_B)
  );

endmodule

// File: tb/tb_bit_flip.sv
// ---------------------------------------------------------------------------
// tb_bit_flip
//
// Purpose:
//   Self-checking bench for bit_flip. Four instances are built with address
//   widths 1, 2, 3 and 5 (74-bit data) and driven side by side. Expected
//   outputs come from a reference that rebuilds each reversed address by
//   reading source bits from LSB upward and shifting them into the result.
// ---------------------------------------------------------------------------
module tb_bit_flip;

  localparam int WS   = 74;
  localparam int NDUT = 4;

  logic i_CLK = 1'b0;
  logic i_RST = 1'b0;

  int addr_w [NDUT] = '{1, 2, 3, 5};

  logic [4:0]    addr_a [NDUT];
  logic [4:0]    addr_b [NDUT];
  logic [WS-1:0] data_a [NDUT];
  logic [WS-1:0] data_b [NDUT];

  logic [4:0]    got_addr_a [NDUT];
  logic [4:0]    got_addr_b [NDUT];
  logic [WS-1:0] got_data_a [NDUT];
  logic [WS-1:0] got_data_b [NDUT];

  int compared   = 0;
  int mismatched = 0;

  always #5 i_CLK = ~i_CLK;

  // Four instances differing only in address width.
  bit_flip_if #(.WORD_SIZE(WS), .ADDR_SIZE(1)) pipe_w1 ();
  bit_flip_if #(.WORD_SIZE(WS), .ADDR_SIZE(2)) pipe_w2 ();
  bit_flip_if #(.WORD_SIZE(WS), .ADDR_SIZE(3)) pipe_w3 ();
  bit_flip_if #(.WORD_SIZE(WS), .ADDR_SIZE(5)) pipe_w5 ();

  bit_flip #(.WORD_SIZE(WS), .ADDR_SIZE(1)) dut_w1 (.i_CLK(i_CLK), .i_RST(i_RST), .pipe(pipe_w1.slave));
  bit_flip #(.WORD_SIZE(WS), .ADDR_SIZE(2)) dut_w2 (.i_CLK(i_CLK), .i_RST(i_RST), .pipe(pipe_w2.slave));
  bit_flip #(.WORD_SIZE(WS), .ADDR_SIZE(3)) dut_w3 (.i_CLK(i_CLK), .i_RST(i_RST), .pipe(pipe_w3.slave));
  bit_flip #(.WORD_SIZE(WS), .ADDR_SIZE(5)) dut_w5 (.i_CLK(i_CLK), .i_RST(i_RST), .pipe(pipe_w5.slave));

  assign pipe_w1.i_pipeaddr_A = addr_a[0][0:0];
  assign pipe_w1.i_pipeaddr_B = addr_b[0][0:0];
  assign pipe_w1.i_pipedata_A = data_a[0];
  assign pipe_w1.i_pipedata_B = data_b[0];
  assign pipe_w2.i_pipeaddr_A = addr_a[1][1:0];
  assign pipe_w2.i_pipeaddr_B = addr_b[1][1:0];
  assign pipe_w2.i_pipedata_A = data_a[1];
  assign pipe_w2.i_pipedata_B = data_b[1];
  assign pipe_w3.i_pipeaddr_A = addr_a[2][2:0];
  assign pipe_w3.i_pipeaddr_B = addr_b[2][2:0];
  assign pipe_w3.i_pipedata_A = data_a[2];
  assign pipe_w3.i_pipedata_B = data_b[2];
  assign pipe_w5.i_pipeaddr_A = addr_a[3];
  assign pipe_w5.i_pipeaddr_B = addr_b[3];
  assign pipe_w5.i_pipedata_A = data_a[3];
  assign pipe_w5.i_pipedata_B = data_b[3];

  assign got_addr_a[0] = 5'(pipe_w1.o_pipeaddr_A);
  assign got_addr_b[0] = 5'(pipe_w1.o_pipeaddr_B);
  assign got_data_a[0] = pipe_w1.o_pipedata_A;
  assign got_data_b[0] = pipe_w1.o_pipedata_B;
  assign got_addr_a[1] = 5'(pipe_w2.o_pipeaddr_A);
  assign got_addr_b[1] = 5'(pipe_w2.o_pipeaddr_B);
  assign got_data_a[1] = pipe_w2.o_pipedata_A;
  assign got_data_b[1] = pipe_w2.o_pipedata_B;
  assign got_addr_a[2] = 5'(pipe_w3.o_pipeaddr_A);
  assign got_addr_b[2] = 5'(pipe_w3.o_pipeaddr_B);
  assign got_data_a[2] = pipe_w3.o_pipedata_A;
  assign got_data_b[2] = pipe_w3.o_pipedata_B;
  assign got_addr_a[3] = pipe_w5.o_pipeaddr_A;
  assign got_addr_b[3] = pipe_w5.o_pipeaddr_B;
  assign got_data_a[3] = pipe_w5.o_pipedata_A;
  assign got_data_b[3] = pipe_w5.o_pipedata_B;

  // Reference reversal: take source bits LSB first and push each one in at
  // the bottom of the result, so the first bit read ends up on top.
  function automatic int revRef(input int a, input int w);
    int r;
    r = 0;
    for (int k = 0; k < w; k++) r = (r << 1) | ((a >> k) & 1);
    return r;
  endfunction

  function automatic logic [WS-1:0] randWord();
    logic [95:0] raw;
    raw = {$urandom, $urandom, $urandom};
    return raw[WS-1:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [WS-1:0] got, input logic [WS-1:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic setLane(input int d, input int a, input int b,
                         input logic [WS-1:0] da, input logic [WS-1:0] db);
    int mask;
    mask      = (1 << addr_w[d]) - 1;
    addr_a[d] = 5'(a & mask);
    addr_b[d] = 5'(b & mask);
    data_a[d] = da;
    data_b[d] = db;
  endtask

  task automatic randomizeAll();
    for (int d = 0; d < NDUT; d++)
      setLane(d, int'($urandom), int'($urandom), randWord(), randWord());
  endtask

  task automatic checkZero(input string tag);
    for (int d = 0; d < NDUT; d++) begin
      checkOutput($sformatf("%s w%0d addrA", tag, addr_w[d]), WS'(got_addr_a[d]), '0);
      checkOutput($sformatf("%s w%0d addrB", tag, addr_w[d]), WS'(got_addr_b[d]), '0);
      checkOutput($sformatf("%s w%0d dataA", tag, addr_w[d]), got_data_a[d], '0);
      checkOutput($sformatf("%s w%0d dataB", tag, addr_w[d]), got_data_b[d], '0);
    end
  endtask

  // One clock: the inputs currently driven are what the edge captures, so
  // the expected outputs are computed from them and checked 1 time unit later.
  task automatic applyStimulus(input string tag);
    logic [WS-1:0] exp_addr_a [NDUT];
    logic [WS-1:0] exp_addr_b [NDUT];
    logic [WS-1:0] exp_data_a [NDUT];
    logic [WS-1:0] exp_data_b [NDUT];
    for (int d = 0; d < NDUT; d++) begin
      exp_addr_a[d] = WS'(revRef(int'(addr_a[d]), addr_w[d]));
      exp_addr_b[d] = WS'(revRef(int'(addr_b[d]), addr_w[d]));
      exp_data_a[d] = data_a[d];
      exp_data_b[d] = data_b[d];
    end
    @(posedge i_CLK);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      checkOutput($sformatf("%s w%0d addrA", tag, addr_w[d]), WS'(got_addr_a[d]), exp_addr_a[d]);
      checkOutput($sformatf("%s w%0d addrB", tag, addr_w[d]), WS'(got_addr_b[d]), exp_addr_b[d]);
      checkOutput($sformatf("%s w%0d dataA", tag, addr_w[d]), got_data_a[d], exp_data_a[d]);
      checkOutput($sformatf("%s w%0d dataB", tag, addr_w[d]), got_data_b[d], exp_data_b[d]);
    end
  endtask

  initial begin
    logic [WS-1:0] pat_a;
    logic [WS-1:0] pat_b;
    int            stream_exp [4] = '{0, 2, 1, 3};

    pat_a = {37{2'b10}};
    pat_b = {37{2'b01}};

    for (int d = 0; d < NDUT; d++) setLane(d, 0, 0, '0, '0);

    // Power-on reset, checked without any clock edge in between.
    #1 i_RST = 1'b1;
    #2 checkZero("por");
    randomizeAll();
    @(negedge i_CLK);
    @(negedge i_CLK);
    checkZero("por held");
    i_RST = 1'b0;

    // Directed vectors across the four widths, data patterns alternating bits.
    setLane(0, 1, 0, pat_a, pat_b);
    setLane(1, 1, 3, pat_a, pat_b);
    setLane(2, 1, 6, pat_a, pat_b);
    setLane(3, 5'h01, 5'h1F, pat_a, pat_b);
    applyStimulus("dir1");
    checkOutput("w1 addr1",     WS'(got_addr_a[0]), WS'(1));
    checkOutput("w2 A1->2",     WS'(got_addr_a[1]), WS'(2));
    checkOutput("w2 B3->3",     WS'(got_addr_b[1]), WS'(3));
    checkOutput("w3 A1->4",     WS'(got_addr_a[2]), WS'(4));
    checkOutput("w3 B6->3",     WS'(got_addr_b[2]), WS'(3));
    checkOutput("w5 A01->10",   WS'(got_addr_a[3]), WS'(5'h10));
    checkOutput("w5 B1F->1F",   WS'(got_addr_b[3]), WS'(5'h1F));
    checkOutput("data 2AA",     got_data_a[3], pat_a);
    checkOutput("data 155",     got_data_b[3], pat_b);

    setLane(2, 3, 4, '1, '1);
    setLane(3, 0, 0, '1, '1);
    applyStimulus("dir2");
    checkOutput("w3 A3->6",     WS'(got_addr_a[2]), WS'(6));
    checkOutput("w3 B4->1",     WS'(got_addr_b[2]), WS'(1));
    checkOutput("w5 zero",      WS'(got_addr_a[3]), WS'(0));
    checkOutput("data ones",    got_data_a[2], {WS{1'b1}});

    // Streaming 0,1,2,3 on the 2-bit instance with fresh data each cycle.
    for (int i = 0; i < 4; i++) begin
      randomizeAll();
      setLane(1, i, 3 - i, randWord(), randWord());
      applyStimulus($sformatf("stream%0d", i));
      checkOutput($sformatf("stream%0d w2 A", i), WS'(got_addr_a[1]), WS'(stream_exp[i]));
    end

    // Random traffic, including equal and swapped addresses on the lanes.
    for (int n = 0; n < 150; n++) begin
      randomizeAll();
      if (n % 10 == 3) for (int d = 0; d < NDUT; d++) addr_b[d] = addr_a[d];
      applyStimulus($sformatf("rand%0d", n));
    end

    // Mid-stream reset between edges: outputs clear at once, in-flight pair lost.
    randomizeAll();
    #2 i_RST = 1'b1;
    #1 checkZero("rst async");
    randomizeAll();
    @(posedge i_CLK);
    #1 checkZero("rst held");
    @(negedge i_CLK);
    i_RST = 1'b0;
    randomizeAll();
    #1 checkZero("rst released");
    applyStimulus("post rst");

    for (int n = 0; n < 20; n++) begin
      randomizeAll();
      applyStimulus($sformatf("tail%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bit_flip.md
BIT_FLIP -- requirements
Module: bit_flip

Interface
REQ-001 The module SHALL have parameter WORD_SIZE, default 74, giving the data word width in bits (minimum 1).
REQ-002 The module SHALL have parameter ADDR_SIZE, default 5, giving the address width in bits to be reversed (minimum 1).
REQ-003 The module SHALL have port i_CLK, input, 1 bit: clock; all state updates occur on the rising edge.
REQ-004 The module SHALL have port i_RST, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The module SHALL have port i_pipeaddr_A, input, ADDR_SIZE bits: lane A source address.
REQ-006 The module SHALL have port i_pipeaddr_B, input, ADDR_SIZE bits: lane B source address.
REQ-007 The module SHALL have port i_pipedata_A, input, WORD_SIZE bits: lane A data word.
REQ-008 The module SHALL have port i_pipedata_B, input, WORD_SIZE bits: lane B data word.
REQ-009 The module SHALL have port o_pipeaddr_A, output, ADDR_SIZE bits: registered, bit-reversed lane A address.
REQ-010 The module SHALL have port o_pipeaddr_B, output, ADDR_SIZE bits: registered, bit-reversed lane B address.
REQ-011 The module SHALL have port o_pipedata_A, output, WORD_SIZE bits: registered lane A data.
REQ-012 The module SHALL have port o_pipedata_B, output, WORD_SIZE bits: registered lane B data.

Function
REQ-013 On each rising edge of i_CLK with i_RST low, o_pipeaddr_A SHALL load the bit reversal of i_pipeaddr_A: output bit k = input bit ADDR_SIZE-1-k, for k = 0 .. ADDR_SIZE-1.
REQ-014 Lane B SHALL apply the same rule, independently: o_pipeaddr_B loads the bit reversal of i_pipeaddr_B.
REQ-015 On the same edge, o_pipedata_A SHALL load i_pipedata_A unmodified, and o_pipedata_B SHALL load i_pipedata_B unmodified.
REQ-016 Latency SHALL be exactly one clock cycle on all four paths, so address and data presented together appear together one edge later.
REQ-017 The module SHALL accept a new address/data pair on every cycle: throughput one pair per lane per clock, with no stall, no enable and no handshake.
REQ-018 Lanes A and B SHALL have no cross-coupling: equal or swapped input addresses on the two lanes need no special handling.
REQ-019 There SHALL be no combinational path from any input to any output; all outputs come directly from flops.
REQ-020 For ADDR_SIZE = 1, address reversal SHALL be the identity.
REQ-021 Palindromic addresses (e.g. 0, all-ones) SHALL map to themselves.
REQ-022 Address arithmetic such as offsetting SHALL NOT be performed inside this block; the caller adds any destination offset.

Reset
REQ-023 While i_RST is high, all four outputs SHALL be forced to 0 immediately, without waiting for a clock edge.
REQ-024 Reset asserted mid-stream SHALL discard the in-flight pair.
REQ-025 On the first rising edge after i_RST deasserts, the outputs SHALL capture the current inputs per REQ-013 to REQ-015.

Structure
REQ-026 A shared package SHALL hold a parameterised bit-reverse function, so the writeback side of the FFT pipeline uses one common definition of the reversal.
REQ-027 A single sub-module, bit_flip_lane (one address register plus one data register), SHALL be instantiated twice, once for lane A and once for lane B.
REQ-028 No other sub-modules are required.

Verification
REQ-029 ADDR_SIZE=2, WORD_SIZE=74: drive A addr 1 and B addr 3 at edge n -> at edge n+1, o_pipeaddr_A=2 and o_pipeaddr_B=3.
REQ-030 ADDR_SIZE=3: A addr 1 and B addr 6 -> one cycle later A=4 and B=3; then A addr 3 and B addr 4 -> next cycle A=6 and B=1.
REQ-031 Data path: A data 0x2AA..A and B data 0x155..5 -> identical values on the outputs one cycle later; an all-ones word passes unchanged.
REQ-032 Streaming: A addresses 0,1,2,3 (ADDR_SIZE=2) on consecutive clocks -> outputs 0,2,1,3 on consecutive clocks, with data staying aligned to its address.
REQ-033 Reset: assert i_RST between clock edges mid-stream -> all outputs 0 in the same cycle; after deassertion the first edge shows the current inputs processed.
REQ-034 Edge widths: ADDR_SIZE=1 with addr 1 -> output 1; ADDR_SIZE=5 with addr 0x01 -> 0x10, and addr 0x1F -> 0x1F.
